// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional oversample/bit tick generator with shadowed runtime config and resync
module uart_baud_gen_frac #(
  parameter int CNT_W        = 16,
  parameter int FRAC_W       = 8,
  parameter int OS_W         = 6,
  parameter int DEF_DIV_INT  = 325,
  parameter int DEF_DIV_FRAC = 133,
  parameter int DEF_OS       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic [OS_W-1:0]   cfg_os,
  input  logic              cfg_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic [OS_W-1:0]   os_phase,
  output logic              cfg_err
);
  localparam logic [CNT_W-1:0]  DEF_INT  = CNT_W'(DEF_DIV_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV_FRAC);
  localparam logic [OS_W-1:0]   DEF_OSV  = OS_W'(DEF_OS);
  localparam logic [CNT_W-1:0]  INT_MIN  = CNT_W'(2);
  localparam logic [OS_W-1:0]   OS_MIN   = OS_W'(2);
  localparam logic [OS_W-1:0]   OS_ONE   = OS_W'(1);
  localparam logic [CNT_W:0]    CNT_ONE  = (CNT_W+1)'(1);
  logic [CNT_W-1:0]  sh_div_int_q, sh_div_int_d, act_div_int_q, act_div_int_d, div_cnt_q, div_cnt_d;
  logic [FRAC_W-1:0] sh_div_frac_q, sh_div_frac_d, act_div_frac_q, act_div_frac_d, frac_acc_q, frac_acc_d;
  logic [OS_W-1:0]   sh_os_q, sh_os_d, act_os_q, act_os_d, os_cnt_q, os_cnt_d, os_phase_q, os_phase_d;
  logic              pend_q, pend_d, cfg_err_q, cfg_err_d, os_tick_q, os_tick_d, bit_tick_q, bit_tick_d;
  logic [FRAC_W:0]   sum;
  logic [CNT_W:0]    period, cnt_nxt;
  logic              hit, apply, wrap;
  // Shadow/apply of config, fractional period timing, and oversample phase tracking.
  // os_cnt is the index the next os_tick will carry; os_phase is the index of the latest one.
  always_comb begin
    sum            = {1'b0, frac_acc_q} + {1'b0, act_div_frac_q};
    period         = {1'b0, act_div_int_q} + {{CNT_W{1'b0}}, sum[FRAC_W]};
    cnt_nxt        = {1'b0, div_cnt_q} + CNT_ONE;
    hit            = en && !resync && (cnt_nxt >= period);
    apply          = pend_q && (!en || resync || hit);
    wrap           = os_cnt_q >= act_os_q - OS_ONE;
    sh_div_int_d   = cfg_load ? cfg_div_int : sh_div_int_q;
    sh_div_frac_d  = cfg_load ? cfg_div_frac : sh_div_frac_q;
    sh_os_d        = cfg_load ? cfg_os : sh_os_q;
    pend_d         = cfg_load || (pend_q && !apply);
    act_div_int_d  = !apply ? act_div_int_q : (sh_div_int_q < INT_MIN) ? INT_MIN : sh_div_int_q;
    act_div_frac_d = apply ? sh_div_frac_q : act_div_frac_q;
    act_os_d       = !apply ? act_os_q : (sh_os_q < OS_MIN) ? OS_MIN : sh_os_q;
    cfg_err_d      = apply ? ((sh_div_int_q < INT_MIN) || (sh_os_q < OS_MIN)) : cfg_err_q;
    div_cnt_d      = (!en || resync || hit) ? '0 : cnt_nxt[CNT_W-1:0];
    frac_acc_d     = (!en || resync) ? '0 : hit ? sum[FRAC_W-1:0] : frac_acc_q;
    os_cnt_d       = !en ? '0 : resync ? (act_os_d >> 1) : hit ? (wrap ? '0 : os_cnt_q + OS_ONE) : os_cnt_q;
    os_phase_d     = !en ? '0 : resync ? (act_os_d >> 1) : hit ? os_cnt_q : os_phase_q;
    os_tick_d      = hit;
    bit_tick_d     = hit && wrap;
  end
  // State registers with asynchronous active-low reset to the default configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_div_int_q   <= DEF_INT;
      sh_div_frac_q  <= DEF_FRAC;
      sh_os_q        <= DEF_OSV;
      act_div_int_q  <= DEF_INT;
      act_div_frac_q <= DEF_FRAC;
      act_os_q       <= DEF_OSV;
      pend_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      div_cnt_q      <= '0;
      frac_acc_q     <= '0;
      os_cnt_q       <= '0;
      os_phase_q     <= '0;
      os_tick_q      <= 1'b0;
      bit_tick_q     <= 1'b0;
    end else begin
      sh_div_int_q   <= sh_div_int_d;
      sh_div_frac_q  <= sh_div_frac_d;
      sh_os_q        <= sh_os_d;
      act_div_int_q  <= act_div_int_d;
      act_div_frac_q <= act_div_frac_d;
      act_os_q       <= act_os_d;
      pend_q         <= pend_d;
      cfg_err_q      <= cfg_err_d;
      div_cnt_q      <= div_cnt_d;
      frac_acc_q     <= frac_acc_d;
      os_cnt_q       <= os_cnt_d;
      os_phase_q     <= os_phase_d;
      os_tick_q      <= os_tick_d;
      bit_tick_q     <= bit_tick_d;
    end
  end
  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign os_phase = os_phase_q;
  assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: randomized and directed checks of tick timing against a closed-form model
module tb_uart_baud_gen_frac;
  localparam int CNT_W = 16, FRAC_W = 8, OS_W = 6;
  logic clk = 0, rst_n = 0, en = 0, cfg_load = 0, resync = 0;
  logic [CNT_W-1:0] cfg_div_int = '0;
  logic [FRAC_W-1:0] cfg_div_frac = '0;
  logic [OS_W-1:0] cfg_os = '0;
  logic os_tick, bit_tick, cfg_err;
  logic [OS_W-1:0] os_phase;
  int cyc = 0, total = 0, bad = 0;
  int obs_t[$];
  bit obs_b[$];
  int obs_p[$];

  uart_baud_gen_frac dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .cfg_os(cfg_os), .cfg_load(cfg_load), .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick),
    .os_phase(os_phase), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Tick log: edge number, bit flag and phase of every os_tick seen
  always @(negedge clk) if (os_tick) begin obs_t.push_back(cyc); obs_b.push_back(bit_tick); obs_p.push_back(int'(os_phase)); end

  // Tick k (0-based) of a run started at edge 0: elapsed = (k+1)*div + floor((k+1)*frac/2^FRAC_W)
  function automatic int exp_time(int div, int frac, int k);
    return (k + 1) * div + (((k + 1) * frac) >> FRAC_W);
  endfunction

  task automatic clear_obs(); obs_t.delete(); obs_b.delete(); obs_p.delete(); endtask
  task automatic step(int n); repeat (n) @(negedge clk); endtask
  task automatic step_to(int c); while (cyc < c) @(negedge clk); endtask
  task automatic wait_ticks(int n, int limit);
    for (int i = 0; i < limit && obs_t.size() < n; i++) @(negedge clk);
    #1;
  endtask
  task automatic load_cfg(int d, int f, int o);
    cfg_div_int = CNT_W'(d); cfg_div_frac = FRAC_W'(f); cfg_os = OS_W'(o); cfg_load = 1;
    @(negedge clk); cfg_load = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; step(3);
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL reset_os_tick got=%0b want=0", os_tick); end
    total++; if (bit_tick !== 1'b0) begin bad++; $display("FAIL reset_bit_tick got=%0b want=0", bit_tick); end
    total++; if (os_phase !== '0) begin bad++; $display("FAIL reset_os_phase got=%0d want=0", os_phase); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%0b want=0", cfg_err); end
    rst_n = 1; step(2);
  endtask

  task automatic test_default();
    int s;
    clear_obs(); en = 1; s = cyc;
    wait_ticks(256, 84000);
    total++; if (obs_t.size() < 256) begin bad++; $display("FAIL default_timeout got=%0d want=256 ticks", obs_t.size()); end
    for (int k = 0; k < 256 && k < obs_t.size(); k++) begin
      total++;
      if (obs_t[k] !== s + exp_time(325, 133, k) || obs_b[k] !== ((k % 16) == 15) || obs_p[k] !== k % 16) begin
        bad++; $display("FAIL default_tick%0d got=t%0d/b%0b/p%0d want=t%0d/b%0b/p%0d", k, obs_t[k] - s, obs_b[k], obs_p[k],
                        exp_time(325, 133, k), (k % 16) == 15, k % 16);
      end
    end
    if (obs_t.size() >= 256) begin
      total++; if (obs_t[255] - s !== 83333) begin bad++; $display("FAIL default_total got=%0d want=83333", obs_t[255] - s); end
    end
    en = 0; step(2);
  endtask

  task automatic test_frac_alt();
    int s;
    load_cfg(3, 128, 4); step(2);
    clear_obs(); en = 1; s = cyc;
    wait_ticks(12, 200);
    total++; if (obs_t.size() < 12) begin bad++; $display("FAIL frac_timeout got=%0d want=12 ticks", obs_t.size()); end
    for (int k = 0; k < 12 && k < obs_t.size(); k++) begin
      total++;
      if (obs_t[k] !== s + exp_time(3, 128, k) || obs_b[k] !== ((k % 4) == 3) || obs_p[k] !== k % 4) begin
        bad++; $display("FAIL frac_tick%0d got=t%0d/b%0b/p%0d want=t%0d/b%0b/p%0d", k, obs_t[k] - s, obs_b[k], obs_p[k],
                        exp_time(3, 128, k), (k % 4) == 3, k % 4);
      end
    end
    if (obs_t.size() >= 8) begin
      total++; if (obs_t[7] - obs_t[3] !== 14) begin bad++; $display("FAIL frac_bit_spacing got=%0d want=14", obs_t[7] - obs_t[3]); end
    end
    en = 0; step(2);
  endtask

  task automatic test_resync();
    int r0;
    load_cfg(4, 0, 16); step(2);
    en = 1; step($urandom_range(5, 60));
    resync = 1; @(negedge clk); r0 = cyc; resync = 0; clear_obs();
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL resync_tick_after got=%0b want=0", os_tick); end
    total++; if (os_phase !== OS_W'(8)) begin bad++; $display("FAIL resync_phase_load got=%0d want=8", os_phase); end
    wait_ticks(10, 100);
    for (int k = 0; k < 10 && k < obs_t.size(); k++) begin
      total++;
      if (obs_t[k] !== r0 + 4 * (k + 1) || obs_b[k] !== (k == 7) || obs_p[k] !== (8 + k) % 16) begin
        bad++; $display("FAIL resync_tick%0d got=t%0d/b%0b/p%0d want=t%0d/b%0b/p%0d", k, obs_t[k] - r0, obs_b[k], obs_p[k],
                        4 * (k + 1), k == 7, (8 + k) % 16);
      end
    end
    total++; if (obs_t.size() < 10) begin bad++; $display("FAIL resync_timeout got=%0d want=10 ticks", obs_t.size()); end
    en = 0; step(2);
  endtask

  task automatic test_reconfig();
    int s, e;
    load_cfg(10, 0, 4); step(2);
    clear_obs(); en = 1; s = cyc;
    step_to(s + 20 + $urandom_range(1, 9) - 1);
    load_cfg(5, 0, 4);
    wait_ticks(8, 200);
    total++; if (obs_t.size() < 8) begin bad++; $display("FAIL reconfig_timeout got=%0d want=8 ticks", obs_t.size()); end
    for (int k = 0; k < 8 && k < obs_t.size(); k++) begin
      e = (k < 3) ? 10 * (k + 1) : 30 + 5 * (k - 2);
      total++;
      if (obs_t[k] !== s + e || obs_b[k] !== ((k % 4) == 3) || obs_p[k] !== k % 4) begin
        bad++; $display("FAIL reconfig_tick%0d got=t%0d/b%0b/p%0d want=t%0d/b%0b/p%0d", k, obs_t[k] - s, obs_b[k], obs_p[k],
                        e, (k % 4) == 3, k % 4);
      end
    end
    en = 0; step(2);
  endtask

  task automatic test_clamp();
    int s;
    load_cfg(0, 0, 1); step(2);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL clamp_err_set got=%0b want=1", cfg_err); end
    clear_obs(); en = 1; s = cyc;
    wait_ticks(6, 50);
    total++; if (obs_t.size() < 6) begin bad++; $display("FAIL clamp_timeout got=%0d want=6 ticks", obs_t.size()); end
    for (int k = 0; k < 6 && k < obs_t.size(); k++) begin
      total++;
      if (obs_t[k] !== s + 2 * (k + 1) || obs_b[k] !== ((k % 2) == 1) || obs_p[k] !== k % 2) begin
        bad++; $display("FAIL clamp_tick%0d got=t%0d/b%0b/p%0d want=t%0d/b%0b/p%0d", k, obs_t[k] - s, obs_b[k], obs_p[k],
                        2 * (k + 1), (k % 2) == 1, k % 2);
      end
    end
    load_cfg(4, 0, 4); step(6);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL clamp_err_clear got=%0b want=0", cfg_err); end
    en = 0; step(2);
  endtask

  task automatic test_collision();
    int s, s3, sr;
    load_cfg(6, 0, 4); step(2);
    clear_obs(); en = 1; s = cyc;
    step_to(s + 11); resync = 1; @(negedge clk); resync = 0;
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL coll_resync_suppress got=%0b want=0", os_tick); end
    total++; if (os_phase !== OS_W'(2)) begin bad++; $display("FAIL coll_resync_phase got=%0d want=2", os_phase); end
    step_to(s + 18);
    total++; if (os_tick !== 1'b1 || os_phase !== OS_W'(2)) begin bad++; $display("FAIL coll_after_resync got=%0b/p%0d want=1/p2", os_tick, os_phase); end
    step_to(s + 23); en = 0; @(negedge clk);
    total++; if (os_tick !== 1'b0 || os_phase !== '0) begin bad++; $display("FAIL coll_en_drop got=%0b/p%0d want=0/p0", os_tick, os_phase); end
    en = 1; step(9); en = 0; @(negedge clk); en = 1; s3 = cyc; clear_obs();
    wait_ticks(4, 60);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= obs_t.size() || obs_t[k] !== s3 + 6 * (k + 1) || obs_p[k] !== k % 4) begin
        bad++; $display("FAIL coll_restart_tick%0d got=%0d want=%0d", k, (k < obs_t.size()) ? obs_t[k] - s3 : -1, 6 * (k + 1));
      end
    end
    step_to(s3 + 30);
    total++; if (os_tick !== 1'b1) begin bad++; $display("FAIL coll_pre_reset_tick got=%0b want=1", os_tick); end
    #1 rst_n = 0; #1;
    total++; if (os_tick !== 1'b0 || bit_tick !== 1'b0 || os_phase !== '0 || cfg_err !== 1'b0) begin
      bad++; $display("FAIL coll_async_reset got=%0b%0b/p%0d/e%0b want=00/p0/e0", os_tick, bit_tick, os_phase, cfg_err);
    end
    @(negedge clk); clear_obs(); rst_n = 1; sr = cyc;
    wait_ticks(1, 400);
    total++; if (obs_t.size() < 1 || obs_t[0] !== sr + exp_time(325, 133, 0) || obs_p[0] !== 0) begin
      bad++; $display("FAIL coll_post_reset_first got=%0d want=%0d", (obs_t.size() > 0) ? obs_t[0] - sr : -1, exp_time(325, 133, 0));
    end
    en = 0; step(2);
  endtask

  task automatic test_random();
    int d, f, o, s, n;
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(2, 12); f = $urandom_range(0, 255); o = $urandom_range(2, 8); n = 3 * o;
      load_cfg(d, f, o); step(2);
      clear_obs(); en = 1; s = cyc;
      wait_ticks(n, n * 14 + 20);
      total++; if (obs_t.size() < n) begin bad++; $display("FAIL rand%0d_timeout got=%0d want=%0d ticks", it, obs_t.size(), n); end
      for (int k = 0; k < n && k < obs_t.size(); k++) begin
        total++;
        if (obs_t[k] !== s + exp_time(d, f, k) || obs_b[k] !== ((k % o) == o - 1) || obs_p[k] !== k % o) begin
          bad++; $display("FAIL rand%0d_tick%0d d=%0d f=%0d o=%0d got=t%0d/b%0b/p%0d want=t%0d/b%0b/p%0d", it, k, d, f, o,
                          obs_t[k] - s, obs_b[k], obs_p[k], exp_time(d, f, k), (k % o) == o - 1, k % o);
        end
      end
      en = 0; step(2);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_frac_alt();
    test_resync();
    test_reconfig();
    test_clamp();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
